lut_ram_scan: RTL and testbench

- Parametrised successor to the fixed 4x3 combinational LED lookup table.
- Small writable lookup memory with a registered read port (1-cycle latency) and write-first bypass.
- Built-in auto-scan mode that steps the read address at a divided rate, so all contents can be displayed on LED/SEG.
- Sits between the SWI decode logic and the LED/lcd_* outputs inside top.

---
 rtl/lut_ram_scan_if.sv | 32 +++
 rtl/lut_ram_scan.sv | 94 +++++++++
 tb/tb_lut_ram_scan.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lut_ram_scan_if.sv
// ---------------------------------------------------------------------------
// lut_ram_scan_if
//   Bundles the data-side signals of the lookup RAM: the write port, the
//   manual read address, the scan enable and the three registered outputs.
//   Clock and reset are kept as plain ports on the module itself.
//
//   master : the SWI decode side (drives we/waddr/wdata/raddr/scan_en)
//   slave  : the lookup RAM (drives rdata/scan_addr/scan_wrap)
// ---------------------------------------------------------------------------
interface lut_ram_scan_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 3
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  scan_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  scan_wrap;

  modport master (
    output we, waddr, wdata, raddr, scan_en,
    input  rdata, scan_addr, scan_wrap
  );

  modport slave (
    input  we, waddr, wdata, raddr, scan_en,
    output rdata, scan_addr, scan_wrap
  );
endinterface

// File: rtl/lut_ram_scan.sv
// ---------------------------------------------------------------------------
// lut_ram_scan
//   Small writable lookup memory (DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH
//   bits) with a registered, write-first read port and an auto-scan mode
//   that walks the read address so every word can be shown on LED/SEG.
//
// Ports
//   clk_2     : system clock, rising edge
//   reset_n   : asynchronous active-low reset (clears memory and state)
//   bus.we    : write enable          bus.waddr / bus.wdata : write port
//   bus.raddr : manual read address (used when scan_en = 0)
//   bus.scan_en   : 1 = read address comes from the scan counter
//   bus.rdata     : registered read data, one cycle after the address
//   bus.scan_addr : current scan address register
//   bus.scan_wrap : one-cycle pulse when scan_addr wraps DEPTH-1 -> 0
// ---------------------------------------------------------------------------
module lut_ram_scan #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 3,
  parameter int SCAN_DIV   = 4
) (
  input  logic           clk_2,
  input  logic           reset_n,
  lut_ram_scan_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
  logic [7:0]            div_cnt_q,   div_cnt_d;
  logic                  scan_wrap_q, scan_wrap_d;
  logic [ADDR_WIDTH-1:0] ea;

  // Effective read address switches in the same cycle as scan_en.
  assign ea = bus.scan_en ? scan_addr_q : bus.raddr;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_d       = mem_q;
    scan_addr_d = scan_addr_q;
    div_cnt_d   = div_cnt_q;
    scan_wrap_d = 1'b0;

    if (bus.we) begin
      mem_d[bus.waddr] = bus.wdata;
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    rdata_d = (bus.we && (bus.waddr == ea)) ? bus.wdata : mem_q[ea];

    if (!bus.scan_en) begin
      // Leaving scan mode restarts the next scan at 0 with a full dwell.
      div_cnt_d   = '0;
      scan_addr_d = '0;
    end else if (int'(div_cnt_q) >= SCAN_DIV - 1) begin
      // ">=" also folds any out-of-range count from a bad SCAN_DIV back to 0.
      div_cnt_d   = '0;
      scan_addr_d = scan_addr_q + ADDR_WIDTH'(1);
      scan_wrap_d = (scan_addr_q == LAST_ADDR);
    end else begin
      div_cnt_d   = div_cnt_q + 8'd1;
    end
  end

  // NOTE: the memory words sit inside the reset branch on purpose: the table
  // must read back as all-zero after reset, so it cannot be a plain RAM macro.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      mem_q       <= '{default: '0};
      rdata_q     <= '0;
      scan_addr_q <= '0;
      div_cnt_q   <= '0;
      scan_wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      mem_q       <= mem_d;
      rdata_q     <= rdata_d;
      scan_addr_q <= scan_addr_d;
      div_cnt_q   <= div_cnt_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.scan_addr = scan_addr_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_lut_ram_scan.sv
// ---------------------------------------------------------------------------
// tb_lut_ram_scan
//   Two instances share one stimulus stream: one with SCAN_DIV=4 and one
//   with SCAN_DIV=1. The driver pushes the expected post-edge outputs of
//   both into a queue; a monitor pops and compares 1 time unit after each
//   rising edge.
// ---------------------------------------------------------------------------
module tb_lut_ram_scan;

  logic clk_2;
  logic reset_n;

  lut_ram_scan_if #(.ADDR_WIDTH(2), .DATA_WIDTH(3)) bus4 ();
  lut_ram_scan_if #(.ADDR_WIDTH(2), .DATA_WIDTH(3)) bus1 ();

  lut_ram_scan #(.ADDR_WIDTH(2), .DATA_WIDTH(3), .SCAN_DIV(4)) dut4 (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  lut_ram_scan #(.ADDR_WIDTH(2), .DATA_WIDTH(3), .SCAN_DIV(1)) dut1 (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  typedef struct {
    int rd  [2];
    int sa  [2];
    int sw  [2];
  } exp_t;

  exp_t exp_q [$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: the table is a plain array; the scan position is
  // derived from how many consecutive scan-enabled edges have occurred.
  int   mem_m [4];
  int   n_m   [2];
  int   div_p [2] = '{4, 1};
  bit   hold_rst;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int scan_pos(int k, int n);
    return (n / div_p[k]) % 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem_m[i] = 0;
    n_m[0] = 0;
    n_m[1] = 0;
  endtask

  // Expected outputs right after the coming rising edge.
  task automatic model_edge(bit we, int wa, int wd, int ra, bit se,
                            output exp_t e);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        e.rd[k] = 0; e.sa[k] = 0; e.sw[k] = 0;
      end else begin
        int ea;
        ea      = se ? scan_pos(k, n_m[k]) : ra;
        e.rd[k] = (we && wa == ea) ? wd : mem_m[ea];
        n_m[k]  = se ? n_m[k] + 1 : 0;
        e.sa[k] = scan_pos(k, n_m[k]);
        e.sw[k] = (se && n_m[k] % (4 * div_p[k]) == 0) ? 1 : 0;
      end
    end
    if (reset_n && we) mem_m[wa] = wd;
  endtask

  task automatic step(bit we, int wa, int wd, int ra, bit se);
    exp_t e;
    @(negedge clk_2);
    reset_n = !hold_rst;
    bus4.we = we;  bus4.waddr = 2'(wa); bus4.wdata = 3'(wd);
    bus4.raddr = 2'(ra); bus4.scan_en = se;
    bus1.we = we;  bus1.waddr = 2'(wa); bus1.wdata = 3'(wd);
    bus1.raddr = 2'(ra); bus1.scan_en = se;
    model_edge(we, wa, wd, ra, se, e);
    exp_q.push_back(e);
    @(posedge clk_2);
  endtask

  task automatic rand_step(bit se);
    step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
         $urandom_range(0, 3), se);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic pulse_reset(int hold_cycles, bit se);
    #3;
    reset_n  = 1'b0;
    hold_rst = 1'b1;
    #1;
    check("async_rst_rdata4", bus4.rdata, 0);
    check("async_rst_saddr4", bus4.scan_addr, 0);
    check("async_rst_wrap4",  bus4.scan_wrap, 0);
    check("async_rst_rdata1", bus1.rdata, 0);
    check("async_rst_saddr1", bus1.scan_addr, 0);
    check("async_rst_wrap1",  bus1.scan_wrap, 0);
    model_reset();
    for (int i = 0; i < hold_cycles; i++) rand_step(se);
    hold_rst = 1'b0;
  endtask

  // Monitor: one set of outputs per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata4",     bus4.rdata,     e.rd[0]);
        check("scan_addr4", bus4.scan_addr, e.sa[0]);
        check("scan_wrap4", bus4.scan_wrap, e.sw[0]);
        check("rdata1",     bus1.rdata,     e.rd[1]);
        check("scan_addr1", bus1.scan_addr, e.sa[1]);
        check("scan_wrap1", bus1.scan_wrap, e.sw[1]);
      end
    end
  end

  initial begin
    int load_tbl [4] = '{3, 6, 4, 2};
    bit se;

    reset_n  = 1'b0;
    hold_rst = 1'b1;
    bus4.we = 0; bus4.waddr = 0; bus4.wdata = 0; bus4.raddr = 0; bus4.scan_en = 0;
    bus1.we = 0; bus1.waddr = 0; bus1.wdata = 0; bus1.raddr = 0; bus1.scan_en = 0;
    model_reset();
    step(1, 2, 5, 0, 1);
    step(0, 0, 0, 0, 0);
    hold_rst = 1'b0;

    // Readback of the cleared table.
    for (int a = 0; a < 4; a++) step(0, 0, 0, a, 0);

    // Load table, then manual reads.
    for (int a = 0; a < 4; a++) step(1, a, load_tbl[a], 0, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 3, 0);

    // Write-first bypass and hold afterwards.
    step(1, 1, 5, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 6, 1, 0);

    // Full scan pass plus a little more, exercising the wrap pulse.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);

    // Scan abort at scan_addr=2, div_cnt=1, then re-enable.
    step(0, 0, 0, 3, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    // Reset mid-scan while the SCAN_DIV=1 instance sits at address 3.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    pulse_reset(2, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    // Randomised traffic with occasional scan toggles and resets.
    se = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) se = ~se;
      if ($urandom_range(0, 99) == 0) pulse_reset($urandom_range(1, 3), se);
      else rand_step(se);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_2);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
